// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed big-endian word stream over a byte
// interface, writes it to memory, acknowledges upstream, then releases the CPU.
module prog_loader #(
  parameter int unsigned MAX_WORDS = 16384,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_run,
  output logic        err
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
    S_ACK,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [31:0] k_q, k_d;
  // Low only while in reset, so rx_ready stays low until the first edge after release.
  logic        live_q;
  logic        rx_fire;

  assign rx_fire = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LEN;
      cnt_q   <= 2'd0;
      len_q   <= 32'd0;
      word_q  <= 32'd0;
      k_q     <= 32'd0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      word_q  <= word_d;
      k_q     <= k_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    word_d    = word_q;
    k_d       = k_q;
    rx_ready  = live_q && ((state_q == S_LEN) || (state_q == S_DATA));
    tx_data   = 8'd0;
    tx_valid  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    cpu_run   = 1'b0;
    err       = 1'b0;

    case (state_q)
      S_LEN: begin
        if (rx_fire) begin
          len_d = {len_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (len_d == 32'd0) begin
              state_d = S_RUN;
            end else if (len_d > MAX_WORDS) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          word_d = {word_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = k_q << 2;
        mem_wdata = word_q;
        k_d       = k_q + 32'd1;
        state_d   = (k_d == len_q) ? S_ACK : S_DATA;
      end
      S_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
        if (tx_ready) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cpu_run = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        state_d = S_LEN;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal, empty, oversize, gapped, stalled-ACK
// and reset-abort loads, each checked against hand-computed results.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        err;

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and ACK observer, sampled mid-cycle.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          tx_cycles = 0;
  logic [7:0]  tx_last = 8'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (tx_valid) begin
        tx_cycles = tx_cycles + 1;
        tx_last   = tx_data;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b0;
      return;
    end
    last_hs = cyc;
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_run();
    int t;
    t = 0;
    while (!cpu_run && t < 100) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    #1;
    check("rst_rx_ready",  {31'd0, rx_ready}, 32'd0);
    check("rst_tx_valid",  {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data",   {24'd0, tx_data},  32'd0);
    check("rst_mem_we",    {31'd0, mem_we},   32'd0);
    check("rst_mem_addr",  mem_addr,          32'd0);
    check("rst_mem_wdata", mem_wdata,         32'd0);
    check("rst_cpu_run",   {31'd0, cpu_run},  32'd0);
    check("rst_err",       {31'd0, err},      32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_rx_ready_pre_edge", {31'd0, rx_ready}, 32'd0);
    @(negedge clk);
    check("rel_rx_ready_post_edge", {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw;
    int bt;
    int hs1;
    logic bad;

    // Two-word load, transmitter always ready.
    do_reset();
    bw = wr_addr_q.size();
    bt = tx_cycles;
    send_word(32'd2, 0);
    send_word(32'hDEADBEEF, 0);
    hs1 = last_hs;
    send_word(32'h01234567, 0);
    idle();
    wait_run();
    check("A_cpu_run",   {31'd0, cpu_run}, 32'd1);
    check("A_num_writes", wr_addr_q.size() - bw, 32'd2);
    check("A_addr0",     wr_addr_q[bw],     32'h0);
    check("A_data0",     wr_data_q[bw],     32'hDEADBEEF);
    check("A_we0_cycle", wr_cyc_q[bw],      hs1 + 1);
    check("A_addr1",     wr_addr_q[bw+1],   32'h4);
    check("A_data1",     wr_data_q[bw+1],   32'h01234567);
    check("A_tx_cycles", tx_cycles - bt,    32'd1);
    check("A_tx_data",   {24'd0, tx_last},  32'hAA);
    check("A_rx_ready_run", {31'd0, rx_ready}, 32'd0);

    // Zero-length program.
    do_reset();
    bw = wr_addr_q.size();
    bt = tx_cycles;
    send_word(32'd0, 0);
    idle();
    check("B_cpu_run", {31'd0, cpu_run}, 32'd1);
    check("B_err",     {31'd0, err},     32'd0);
    repeat (3) @(negedge clk);
    check("B_num_writes", wr_addr_q.size() - bw, 32'd0);
    check("B_tx_cycles",  tx_cycles - bt,        32'd0);

    // Length one above the limit, then extra bytes offered.
    do_reset();
    bw = wr_addr_q.size();
    bt = tx_cycles;
    send_word(32'h00004001, 0);
    idle();
    check("C_err",      {31'd0, err},      32'd1);
    check("C_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("C_cpu_run",  {31'd0, cpu_run},  32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rx_ready !== 1'b0 || err !== 1'b1) bad = 1'b1;
    end
    rx_valid = 1'b0;
    check("C_stays_err_unconsumed", {31'd0, bad}, 32'd0);
    check("C_num_writes", wr_addr_q.size() - bw, 32'd0);
    check("C_tx_cycles",  tx_cycles - bt,        32'd0);

    // Length exactly at the limit is accepted.
    do_reset();
    send_word(32'h00004000, 0);
    idle();
    check("C_max_err",      {31'd0, err},      32'd0);
    check("C_max_rx_ready", {31'd0, rx_ready}, 32'd1);

    // One word with idle gaps between bytes.
    do_reset();
    bw = wr_addr_q.size();
    send_word(32'd1, 0);
    send_word(32'hA5C30F96, 5);
    idle();
    wait_run();
    check("D_cpu_run",    {31'd0, cpu_run},      32'd1);
    check("D_num_writes", wr_addr_q.size() - bw, 32'd1);
    check("D_addr",       wr_addr_q[bw],         32'h0);
    check("D_data",       wr_data_q[bw],         32'hA5C30F96);
    check("D_we_cycle",   wr_cyc_q[bw],          last_hs + 1);

    // ACK stalled by the transmitter for 10 cycles.
    do_reset();
    tx_ready = 1'b0;
    bt = tx_cycles;
    send_word(32'd1, 0);
    send_word(32'h12345678, 0);
    idle();
    for (int t = 0; t < 20 && !tx_valid; t++) @(negedge clk);
    check("E_tx_valid_seen", {31'd0, tx_valid}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'hAA || cpu_run !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    check("E_ack_stable", {31'd0, bad}, 32'd0);
    check("E_cpu_run_before_hs", {31'd0, cpu_run}, 32'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    check("E_cpu_run_after_hs",  {31'd0, cpu_run},  32'd1);
    check("E_tx_valid_after_hs", {31'd0, tx_valid}, 32'd0);
    check("E_tx_cycles",         tx_cycles - bt,    32'd11);

    // Reset mid-word, then a fresh load.
    do_reset();
    send_word(32'd1, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    bw = wr_addr_q.size();
    do_reset();
    send_word(32'd1, 0);
    send_word(32'hCAFEBABE, 0);
    idle();
    wait_run();
    check("F_cpu_run",    {31'd0, cpu_run},      32'd1);
    check("F_num_writes", wr_addr_q.size() - bw, 32'd1);
    check("F_addr",       wr_addr_q[bw],         32'h0);
    check("F_data",       wr_data_q[bw],         32'hCAFEBABE);

    // Async reset from RUN drops cpu_run before any clock edge.
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
